uart_baud_generator_frac: RTL and testbench

Parametrised fractional baud-rate generator for the UART, successor to `uart_baud_generator2`. It uses a phase accumulator instead of an integer divider, so any `clock_frequency_register` / `Baud_Rate_Holding_Register` pair gives zero long-term rate error. The oversampling ratio and register width are configurable. Its outputs are an oversample tick, a sample index, mid-bit and bit strobes, and a 50%-duty baud clock for the UART RX and TX blocks. It also provides start-bit phase realignment (`restart`) and invalid-configuration detection.

---
 rtl/uart_baud_generator_frac.sv | 141 ++++++++++++++
 tb/tb_uart_baud_generator_frac.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_generator_frac.sv
// Fractional UART baud-rate generator built on a phase accumulator.
// Each enabled cycle the accumulator gains inc = baud * OVERSAMPLE. Whenever
// it reaches the clock frequency F, F is subtracted and an oversample tick is
// issued. Over F cycles exactly inc ticks are produced, so the long-term rate
// error is zero. A sample counter that runs off the ticks drives the bit
// strobes and a 50%-duty baud clock.
//
// Strobe semantics: os_tick, mid_bit and bit_tick are single-cycle,
// registered pulses. mid_bit and bit_tick only ever fire together with
// os_tick. sampling_pulse and the_new_generated_clock update on the same
// edge as the tick that moves them. Downstream logic samples them without a
// handshake.
module uart_baud_generator_frac #(
  parameter int WIDTH      = 32,
  parameter int OVERSAMPLE = 16,
  parameter int SAMPLE_W   = $clog2(OVERSAMPLE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                restart,
  input  logic [WIDTH-1:0]    Baud_Rate_Holding_Register,
  input  logic [WIDTH-1:0]    clock_frequency_register,
  output logic                os_tick,
  output logic [SAMPLE_W-1:0] sampling_pulse,
  output logic                mid_bit,
  output logic                bit_tick,
  output logic                the_new_generated_clock,
  output logic                cfg_error
);

  // inc needs WIDTH+SAMPLE_W bits to hold baud*OVERSAMPLE without loss.
  // One more bit lets acc+inc (both below 2F) be formed without overflow.
  localparam int IW = WIDTH + SAMPLE_W;
  localparam int AW = IW + 1;

  // Counter values whose increment wraps to 0 or lands on the bit centre.
  localparam logic [SAMPLE_W-1:0] CNT_LAST     = SAMPLE_W'(OVERSAMPLE - 1);
  localparam logic [SAMPLE_W-1:0] CNT_HALF_PRE = SAMPLE_W'(OVERSAMPLE / 2 - 1);

  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] baud_shadow;
  logic [WIDTH-1:0] freq_shadow;

  logic [IW-1:0]    inc;
  logic [AW-1:0]    inc_x;
  logic [AW-1:0]    freq_x;
  logic [AW-1:0]    sum;
  logic             tick_due;
  logic             cfg_bad;
  logic             clear_evt;

  // OVERSAMPLE is a power of two, so the multiply is a left shift.
  assign inc    = {Baud_Rate_Holding_Register, {SAMPLE_W{1'b0}}};
  assign inc_x  = {1'b0, inc};
  assign freq_x = {{(SAMPLE_W + 1){1'b0}}, clock_frequency_register};

  assign sum      = acc + inc_x;
  assign tick_due = (sum >= freq_x);

  // A zero rate, a zero clock, or more ticks requested than clock cycles
  // cannot be generated.
  assign cfg_bad = (Baud_Rate_Holding_Register == '0) ||
                   (clock_frequency_register == '0) ||
                   (inc_x > freq_x);

  // Any register edit, or an explicit restart, realigns the bit phase.
  assign clear_evt = restart ||
                     (Baud_Rate_Holding_Register != baud_shadow) ||
                     (clock_frequency_register != freq_shadow);

  // Shadows track the last-seen configuration. Reloading every cycle is the
  // same as reloading on a mismatch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_shadow <= '0;
      freq_shadow <= '0;
    end else begin
      baud_shadow <= Baud_Rate_Holding_Register;
      freq_shadow <= clock_frequency_register;
    end
  end

  // Configuration check, registered so it lags a register change by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_error <= 1'b0;
    end else begin
      cfg_error <= cfg_bad;
    end
  end

  // Accumulator, sample counter, strobes and baud clock.
  // Priority: clear event, then invalid-config hold, then enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc                     <= '0;
      sampling_pulse          <= '0;
      os_tick                 <= 1'b0;
      mid_bit                 <= 1'b0;
      bit_tick                <= 1'b0;
      the_new_generated_clock <= 1'b0;
    end else if (clear_evt) begin
      // Any tick due in this cycle is discarded.
      acc                     <= '0;
      sampling_pulse          <= '0;
      os_tick                 <= 1'b0;
      mid_bit                 <= 1'b0;
      bit_tick                <= 1'b0;
      the_new_generated_clock <= 1'b0;
    end else if (cfg_error) begin
      // Counter and clock level keep their values. The preceding clear event
      // has already zeroed them.
      acc      <= '0;
      os_tick  <= 1'b0;
      mid_bit  <= 1'b0;
      bit_tick <= 1'b0;
    end else if (enable) begin
      os_tick  <= tick_due;
      mid_bit  <= tick_due && (sampling_pulse == CNT_HALF_PRE);
      bit_tick <= tick_due && (sampling_pulse == CNT_LAST);
      if (tick_due) begin
        acc            <= sum - freq_x;
        sampling_pulse <= sampling_pulse + SAMPLE_W'(1);
        if (sampling_pulse == CNT_HALF_PRE) begin
          the_new_generated_clock <= 1'b1;
        end else if (sampling_pulse == CNT_LAST) begin
          the_new_generated_clock <= 1'b0;
        end
      end else begin
        acc <= sum;
      end
    end else begin
      // Disabled: phase, counter and clock level are frozen.
      os_tick  <= 1'b0;
      mid_bit  <= 1'b0;
      bit_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_baud_generator_frac.sv
// Directed bench for uart_baud_generator_frac (WIDTH=32, OVERSAMPLE=16).
// Stimulus pushes the expected ticks (relative cycle, counter, strobes and
// clock level) into exp_q. A monitor pops and compares one entry on every
// os_tick while the scoreboard is armed, and also keeps running statistics
// for the long fractional-rate checks.
module tb_uart_baud_generator_frac;

  localparam int WIDTH = 32;
  localparam int OS    = 16;
  localparam int SW    = 4;
  localparam int EW    = 39;   // {rel[31:0], sp[3:0], bit_tick, mid_bit, clk}

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic             restart = 1'b0;
  logic [WIDTH-1:0] baud = '0;
  logic [WIDTH-1:0] freq = '0;
  logic             os_tick;
  logic [SW-1:0]    sampling_pulse;
  logic             mid_bit;
  logic             bit_tick;
  logic             gen_clk;
  logic             cfg_error;

  uart_baud_generator_frac #(.WIDTH(WIDTH), .OVERSAMPLE(OS)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .enable                     (enable),
    .restart                    (restart),
    .Baud_Rate_Holding_Register (baud),
    .clock_frequency_register   (freq),
    .os_tick                    (os_tick),
    .sampling_pulse             (sampling_pulse),
    .mid_bit                    (mid_bit),
    .bit_tick                   (bit_tick),
    .the_new_generated_clock    (gen_clk),
    .cfg_error                  (cfg_error)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [EW-1:0] exp_q[$];
  bit          sb_on = 1'b0;
  int unsigned t0 = 0;

  int          tick_cnt, bit_cnt, mid_cnt, stray_cnt, hi_cnt;
  int          gap_min, gap_max, first_rel, last_rel;
  bit          seen;
  int unsigned mon_rel;
  logic [EW-1:0] mon_got, mon_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack(input int unsigned rel, input int sp,
                                         input logic bt, input logic mb, input logic ck);
    logic [31:0] r;
    logic [3:0]  s;
    r = rel;
    s = sp[3:0];
    return {r, s, bt, mb, ck};
  endfunction

  // Expected tick: bit_tick when the counter wraps to 0, mid_bit when it
  // reaches 8, and the baud clock is high while the counter is in 8..15.
  task automatic push_tick(input int unsigned rel, input int sp);
    exp_q.push_back(pack(rel, sp, (sp == 0), (sp == OS / 2), (sp >= OS / 2)));
  endtask

  task automatic clear_stats();
    tick_cnt  = 0;
    bit_cnt   = 0;
    mid_cnt   = 0;
    stray_cnt = 0;
    hi_cnt    = 0;
    gap_min   = 1 << 30;
    gap_max   = 0;
    first_rel = 0;
    last_rel  = 0;
    seen      = 1'b0;
  endtask

  // ---------------- monitor ----------------
  // Sample 1 time unit after each active edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      mon_rel = cyc - t0;
      if (gen_clk) hi_cnt++;
      if ((bit_tick || mid_bit) && !os_tick) stray_cnt++;
      if (os_tick) begin
        tick_cnt++;
        if (bit_tick) bit_cnt++;
        if (mid_bit) mid_cnt++;
        if (seen) begin
          if (int'(mon_rel) - last_rel < gap_min) gap_min = int'(mon_rel) - last_rel;
          if (int'(mon_rel) - last_rel > gap_max) gap_max = int'(mon_rel) - last_rel;
        end else begin
          first_rel = int'(mon_rel);
        end
        seen     = 1'b1;
        last_rel = int'(mon_rel);
        if (sb_on) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tick_sb: unexpected os_tick at rel=%0d, expected none", mon_rel);
          end else begin
            mon_exp = exp_q.pop_front();
            mon_got = pack(mon_rel, int'(sampling_pulse), bit_tick, mid_bit, gen_clk);
            if (mon_got !== mon_exp) begin
              errors++;
              $display("FAIL tick_sb: got rel=%0d sp=%0d bt=%0b mb=%0b clk=%0b expected rel=%0d sp=%0d bt=%0b mb=%0b clk=%0b",
                       mon_got[38:7], mon_got[6:3], mon_got[2], mon_got[1], mon_got[0],
                       mon_exp[38:7], mon_exp[6:3], mon_exp[2], mon_exp[1], mon_exp[0]);
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge. The next active edge is relative cycle 1.
  task automatic start_phase();
    clear_stats();
    t0     = cyc;
    enable = 1'b1;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step(1);
    restart = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_stats();
    freq = 160;
    baud = 1;
    #23;
    chk("reset_os_tick", os_tick, 0);
    chk("reset_sp", sampling_pulse, 0);
    chk("reset_mid_bit", mid_bit, 0);
    chk("reset_bit_tick", bit_tick, 0);
    chk("reset_gen_clk", gen_clk, 0);
    chk("reset_cfg_error", cfg_error, 0);

    @(negedge clk);
    rst = 1'b1;
    step(3);
    chk("cfg_ok_after_reset", cfg_error, 0);

    // Exact ratio: F=160, baud=1 -> tick every 10 cycles.
    start_phase();
    for (int j = 1; j <= 32; j++) push_tick(10 * j, j % OS);
    sb_on = 1'b1;
    step(325);
    sb_on = 1'b0;
    chk("exact_queue_empty", exp_q.size(), 0);
    chk("exact_clk_high", hi_cnt, 160);
    chk("exact_bit_ticks", bit_cnt, 2);
    chk("exact_mid_bits", mid_cnt, 2);
    chk("exact_first_tick", first_rel, 10);

    // Enable dropped for 37 cycles while the baud clock is high.
    enable = 1'b0;
    pulse_restart();
    step(2);
    chk("restart_idle_sp", sampling_pulse, 0);
    start_phase();
    for (int j = 1; j <= 9; j++) push_tick(10 * j, j);
    push_tick(137, 10);
    push_tick(147, 11);
    push_tick(157, 12);
    sb_on = 1'b1;
    step(95);
    enable = 1'b0;
    step(37);
    chk("frozen_sp", sampling_pulse, 9);
    chk("frozen_clk", gen_clk, 1);
    chk("frozen_ticks", tick_cnt, 9);
    enable = 1'b1;
    step(28);
    sb_on = 1'b0;
    chk("freeze_queue_empty", exp_q.size(), 0);
    chk("freeze_stray", stray_cnt, 0);

    // Restart coinciding with the tick that would move the counter 5 -> 6.
    enable = 1'b0;
    pulse_restart();
    step(2);
    start_phase();
    for (int j = 1; j <= 5; j++) push_tick(10 * j, j);
    for (int j = 1; j <= 8; j++) push_tick(60 + 10 * j, j);
    sb_on = 1'b1;
    step(59);
    chk("pre_restart_sp", sampling_pulse, 5);
    pulse_restart();
    chk("restart_os_tick", os_tick, 0);
    chk("restart_sp", sampling_pulse, 0);
    chk("restart_clk", gen_clk, 0);
    step(85);
    sb_on = 1'b0;
    chk("restart_queue_empty", exp_q.size(), 0);
    chk("restart_mid_bits", mid_cnt, 1);

    // Baud change while disabled still clears the phase (inc=32, k=5).
    enable = 1'b0;
    baud = 2;
    step(3);
    chk("cfgchg_sp", sampling_pulse, 0);
    chk("cfgchg_clk", gen_clk, 0);
    chk("cfgchg_cfg_error", cfg_error, 0);
    start_phase();
    for (int j = 1; j <= 4; j++) push_tick(5 * j, j);
    sb_on = 1'b1;
    step(22);
    sb_on = 1'b0;
    chk("cfgchg_queue_empty", exp_q.size(), 0);

    // Extreme rate inc == F: a tick every cycle.
    enable = 1'b0;
    baud = 10;
    step(3);
    chk("extreme_cfg_error", cfg_error, 0);
    start_phase();
    step(32);
    chk("extreme_ticks", tick_cnt, 32);
    chk("extreme_bit_ticks", bit_cnt, 2);
    chk("extreme_gap_max", gap_max, 1);
    chk("extreme_first_tick", first_rel, 1);

    // Fractional: F=1000, baud=6, inc=96.
    enable = 1'b0;
    freq = 1000;
    baud = 6;
    step(3);
    start_phase();
    step(1000);
    chk("frac_ticks_1000", tick_cnt, 96);
    chk("frac_bits_1000", bit_cnt, 6);
    step(9000);
    chk("frac_ticks_10000", tick_cnt, 960);
    chk("frac_bits_10000", bit_cnt, 60);
    chk("frac_mids_10000", mid_cnt, 60);
    chk("frac_gap_min", gap_min, 10);
    chk("frac_gap_max", gap_max, 11);
    chk("frac_first_tick", first_rel, 11);
    chk("frac_last_tick", last_rel, 10000);
    chk("frac_end_sp", sampling_pulse, 0);
    chk("frac_stray", stray_cnt, 0);

    // Invalid: baud=0.
    baud = 0;
    step(1);
    chk("baud0_cfg_error", cfg_error, 1);
    clear_stats();
    step(1000);
    chk("baud0_no_ticks", tick_cnt, 0);
    chk("baud0_no_strobes", stray_cnt, 0);
    chk("baud0_cfg_error_held", cfg_error, 1);
    // Recovery: F=160, baud=1. The change edge clears; ten more edges tick.
    freq = 160;
    baud = 1;
    step(1);
    chk("recover_cfg_error", cfg_error, 0);
    start_phase();
    step(12);
    chk("recover_first_tick", first_rel, 10);
    chk("recover_ticks", tick_cnt, 1);
    // inc=16 > F=10.
    freq = 10;
    step(1);
    chk("inc_gt_f_cfg_error", cfg_error, 1);

    // Asynchronous reset mid-bit, between clock edges.
    enable = 1'b0;
    freq = 160;
    baud = 1;
    step(3);
    chk("prereset_cfg_error", cfg_error, 0);
    start_phase();
    step(85);
    chk("prereset_clk", gen_clk, 1);
    chk("prereset_sp", sampling_pulse, 8);
    #2;
    rst = 1'b0;
    #1;
    chk("areset_os_tick", os_tick, 0);
    chk("areset_sp", sampling_pulse, 0);
    chk("areset_mid_bit", mid_bit, 0);
    chk("areset_bit_tick", bit_tick, 0);
    chk("areset_clk", gen_clk, 0);
    chk("areset_cfg_error", cfg_error, 0);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(2);
    start_phase();
    step(12);
    chk("postreset_first_tick", first_rel, 10);
    chk("postreset_ticks", tick_cnt, 1);
    chk("postreset_sp", sampling_pulse, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
